// File: rtl/packet_ingress_parser_pkg.sv
// Shared types for the ingress parser: the 5-tuple handed to the classifier,
// IPv4 header constants, the parser state encoding and the checksum fold helper.
package packet_ingress_parser_pkg;

   localparam logic [3:0] IPV4_VERSION = 4'd4;
   localparam logic [3:0] MIN_IHL      = 4'd5;
   localparam logic [7:0] PROTO_TCP    = 8'd6;
   localparam logic [7:0] PROTO_UDP    = 8'd17;

   // Field order matches the classifier's packet_s key.
   typedef struct packed {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [7:0]  protocol;
   } tuple_s;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_L4,
      ST_TAIL,
      ST_DRAIN
   } parser_state_e;

   // Fold a 32-bit ones'-complement accumulator to 16 bits. Two folds are
   // enough for any IPv4 header length.
   function automatic logic [15:0] csum_fold(input logic [31:0] sum);
      logic [16:0] f1;
      f1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
      return f1[15:0] + {15'd0, f1[16]};
   endfunction

endpackage

// File: rtl/packet_ingress_parser_if.sv
// Stream input, tuple dispatch and status signals of the ingress parser.
// slave: the parser itself; master: whatever drives the stream and consumes tuples.
interface packet_ingress_parser_if #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
);
   logic                          s_valid;
   logic                          s_ready;
   logic [31:0]                   s_data;
   logic                          s_last;
   logic                          out_valid;
   logic [31:0]                   src_ip;
   logic [31:0]                   dst_ip;
   logic [15:0]                   src_port;
   logic [15:0]                   dst_port;
   logic [7:0]                    protocol;
   logic                          ready_to_process;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;
   logic [CNT_W-1:0]              drop_count;
   logic [CNT_W-1:0]              malformed_count;

   modport slave (
      input  s_valid, s_data, s_last, ready_to_process,
      output s_ready, out_valid, src_ip, dst_ip, src_port, dst_port, protocol,
             fifo_level, drop_count, malformed_count
   );

   modport master (
      output s_valid, s_data, s_last, ready_to_process,
      input  s_ready, out_valid, src_ip, dst_ip, src_port, dst_port, protocol,
             fifo_level, drop_count, malformed_count
   );
endinterface

// File: rtl/packet_ingress_parser_tuple_fifo.sv
// Single-clock tuple FIFO. A push while full is accepted only when a pop
// happens on the same edge; the slot being overwritten is the head leaving.
module packet_ingress_parser_tuple_fifo
   import packet_ingress_parser_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  tuple_s                  din,
   output tuple_s                  dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   LVL_ONE  = 1;
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   tuple_s        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   // Storage write; contents need no reset since level gates validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/packet_ingress_parser.sv
// IPv4 ingress parser: extracts the 5-tuple from a 32-bit word stream,
// queues it and issues it to the classifier one pulse at a time.
// Optional build macro IPV4_CSUM_CHECK_EN adds header checksum verification.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for word 0 (version / IHL check)
// ST_HDR   | header words 1..IHL-1, fields latched as they pass
// ST_L4    | next word carries TCP/UDP ports
// ST_TAIL  | good packet, consuming payload until s_last
// ST_DRAIN | rejected packet, consuming words until s_last
module packet_ingress_parser
   import packet_ingress_parser_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   packet_ingress_parser_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   parser_state_e state_q, state_d;

   logic        acc;
   logic        ver_ok;
   logic        hdr_last;
   logic        l4_ok;
   logic        hdr_end;
   logic        commit;
   logic        malformed;
   logic        csum_bad;
   logic        bad_q;
   logic [3:0]  ihl_q;
   logic [3:0]  word_idx_q;
   logic [12:0] frag_q;
   logic [7:0]  proto_q;
   logic [31:0] src_q;
   logic [31:0] dst_q;
   logic [15:0] sport_q;
   logic [15:0] dport_q;

   tuple_s      commit_tuple;
   tuple_s      head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        issue;
   logic        holdoff_q;
   logic        drop;
   logic [CNT_W-1:0] drop_q;
   logic [CNT_W-1:0] mal_q;

   // The parser never back-pressures; only reset holds the stream off.
   assign bus.s_ready = !reset;
   assign acc         = bus.s_valid && !reset;
   assign ver_ok      = (bus.s_data[31:28] == IPV4_VERSION) && (bus.s_data[27:24] >= MIN_IHL);
   assign hdr_last    = (word_idx_q == ihl_q - 4'd1);
   assign l4_ok       = ((proto_q == PROTO_TCP) || (proto_q == PROTO_UDP)) && (frag_q == '0);

`ifdef IPV4_CSUM_CHECK_EN
   logic [31:0] csum_acc_q;
   logic [31:0] csum_next;
   logic [31:0] word_halves;

   assign word_halves = {16'd0, bus.s_data[31:16]} + {16'd0, bus.s_data[15:0]};
   assign csum_next   = csum_acc_q + word_halves;
   assign csum_bad    = (csum_fold(csum_next) != 16'hFFFF);

   // Running ones'-complement sum over header halves; restarts on word 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         csum_acc_q <= '0;
      end else if (acc && state_q == ST_IDLE) begin
         csum_acc_q <= word_halves;
      end else if (acc && state_q == ST_HDR) begin
         csum_acc_q <= csum_next;
      end
   end
`else
   assign csum_bad = 1'b0;
`endif

   // Parser state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state plus commit / malformed decisions for the word being accepted.
   always_comb begin
      state_d   = state_q;
      commit    = 1'b0;
      malformed = 1'b0;
      hdr_end   = 1'b0;
      if (acc) begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.s_last) malformed = 1'b1;
               else            state_d   = ver_ok ? ST_HDR : ST_DRAIN;
            end
            ST_HDR: begin
               if (bus.s_last) begin
                  malformed = 1'b1;
                  state_d   = ST_IDLE;
               end else if (hdr_last) begin
                  hdr_end = 1'b1;
                  state_d = l4_ok ? ST_L4 : ST_TAIL;
               end
            end
            ST_L4, ST_TAIL: begin
               if (bus.s_last) begin
                  commit    = !bad_q;
                  malformed = bad_q;
                  state_d   = ST_IDLE;
               end else begin
                  state_d   = ST_TAIL;
               end
            end
            ST_DRAIN: begin
               if (bus.s_last) begin
                  malformed = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Header field capture as words stream past.
   always_ff @(posedge clk) begin
      if (reset) begin
         ihl_q      <= '0;
         word_idx_q <= '0;
         frag_q     <= '0;
         proto_q    <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         sport_q    <= '0;
         dport_q    <= '0;
         bad_q      <= 1'b0;
      end else if (acc) begin
         case (state_q)
            ST_IDLE: begin
               ihl_q      <= bus.s_data[27:24];
               word_idx_q <= 4'd1;
               bad_q      <= !ver_ok;
            end
            ST_HDR: begin
               word_idx_q <= word_idx_q + 4'd1;
               case (word_idx_q)
                  4'd1:    frag_q  <= bus.s_data[12:0];
                  4'd2:    proto_q <= bus.s_data[23:16];
                  4'd3:    src_q   <= bus.s_data;
                  4'd4:    dst_q   <= bus.s_data;
                  default: ;
               endcase
               if (hdr_end) begin
                  sport_q <= '0;
                  dport_q <= '0;
                  bad_q   <= csum_bad;
               end
            end
            ST_L4: begin
               sport_q <= bus.s_data[31:16];
               dport_q <= bus.s_data[15:0];
            end
            default: ;
         endcase
      end
   end

   // When the port word is also the last word, take the ports straight off the bus.
   assign commit_tuple.src_ip   = src_q;
   assign commit_tuple.dst_ip   = dst_q;
   assign commit_tuple.src_port = (state_q == ST_L4) ? bus.s_data[31:16] : sport_q;
   assign commit_tuple.dst_port = (state_q == ST_L4) ? bus.s_data[15:0]  : dport_q;
   assign commit_tuple.protocol = proto_q;

   packet_ingress_parser_tuple_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (commit),
      .pop   (issue),
      .din   (commit_tuple),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (bus.fifo_level)
   );

   assign issue = !reset && !fifo_empty && bus.ready_to_process && !holdoff_q;
   assign drop  = commit && fifo_full && !issue;

   // Holdoff blocks a second issue until the classifier has dropped ready.
   always_ff @(posedge clk) begin
      if (reset)                      holdoff_q <= 1'b0;
      else if (issue)                 holdoff_q <= 1'b1;
      else if (!bus.ready_to_process) holdoff_q <= 1'b0;
   end

   // Saturating status counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= '0;
         mal_q  <= '0;
      end else begin
         if (drop && drop_q != '1)     drop_q <= drop_q + CNT_ONE;
         if (malformed && mal_q != '1) mal_q  <= mal_q + CNT_ONE;
      end
   end

   assign bus.out_valid       = issue;
   assign bus.src_ip          = head.src_ip;
   assign bus.dst_ip          = head.dst_ip;
   assign bus.src_port        = head.src_port;
   assign bus.dst_port        = head.dst_port;
   assign bus.protocol        = head.protocol;
   assign bus.drop_count      = drop_q;
   assign bus.malformed_count = mal_q;

endmodule

// File: tb/tb_packet_ingress_parser.sv
// Directed bench for the ingress parser with a tuple scoreboard.
module tb_packet_ingress_parser;
   import packet_ingress_parser_pkg::*;

   localparam int FIFO_DEPTH = 8;
   localparam int CNT_W      = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   packet_ingress_parser_if #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) bus ();

   packet_ingress_parser #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   tuple_s      exp_q [$];
   bit          need_low = 1'b0;
   tuple_s      mon_got;
   tuple_s      mon_want;
   logic [31:0] pw [16];
   int          pn;
   bit          corrupt = 1'b0;
   bit          ready_on_last = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic tuple_s mk(input logic [31:0] s, input logic [31:0] d,
                                 input logic [15:0] sp, input logic [15:0] dp,
                                 input logic [7:0] pr);
      tuple_s t;
      t.src_ip = s; t.dst_ip = d; t.src_port = sp; t.dst_port = dp; t.protocol = pr;
      return t;
   endfunction

   // Monitor: every issue pulse pops the scoreboard and must follow a ready=0 cycle.
   always @(negedge clk) begin
      if (reset) begin
         need_low = 1'b0;
      end else if (bus.out_valid) begin
         mon_got.src_ip   = bus.src_ip;
         mon_got.dst_ip   = bus.dst_ip;
         mon_got.src_port = bus.src_port;
         mon_got.dst_port = bus.dst_port;
         mon_got.protocol = bus.protocol;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_issue: got %h, expected no issue", mon_got);
         end else begin
            mon_want = exp_q.pop_front();
            if (mon_got !== mon_want) begin
               n_errors++;
               $display("FAIL tuple: got %h, expected %h", mon_got, mon_want);
            end
         end
         n_checks++;
         if (need_low) begin
            n_errors++;
            $display("FAIL double_issue: got pulse with no ready=0 since last, expected none");
         end
         need_low = 1'b1;
      end else if (!bus.ready_to_process) begin
         need_low = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_tcp(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] sp, input logic [15:0] dp);
      pn    = 6;
      pw[0] = 32'h45000028;
      pw[1] = 32'h00000000;
      pw[2] = 32'h40060000;
      pw[3] = s;
      pw[4] = d;
      pw[5] = {sp, dp};
   endtask

   task automatic fix_csum();
      logic [3:0]  ihl;
      logic [31:0] sum;
      logic [16:0] f;
      ihl = pw[0][27:24];
      if (pw[0][31:28] == 4'd4 && ihl >= 4'd5 && pn >= int'(ihl)) begin
         pw[2][15:0] = 16'h0000;
         sum = 32'h0;
         for (int i = 0; i < int'(ihl); i++) sum = sum + {16'd0, pw[i][31:16]} + {16'd0, pw[i][15:0]};
         f = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
         f = {1'b0, f[15:0]} + {16'd0, f[16]};
         pw[2][15:0] = ~f[15:0] ^ {15'd0, corrupt};
      end
   endtask

   task automatic send_pkt(input int n_send, input bit end_last);
`ifdef IPV4_CSUM_CHECK_EN
      fix_csum();
`endif
      for (int i = 0; i < n_send; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = pw[i];
         bus.s_last  = end_last && (i == n_send - 1);
         if (ready_on_last && i == n_send - 1) bus.ready_to_process = 1'b1;
         tick();
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = '0;
   endtask

   // Let one pending pulse go out, then drop ready a cycle to clear holdoff.
   task automatic ack();
      @(negedge clk);
      tick();
      bus.ready_to_process = 1'b0;
      tick();
      bus.ready_to_process = 1'b1;
   endtask

   // Classifier model: ready drops for 3 cycles after every pulse.
   task automatic drain(input int n);
      int   got;
      int   cyc;
      logic ov;
      got = 0;
      cyc = 0;
      bus.ready_to_process = 1'b1;
      while (got < n && cyc < 400) begin
         @(negedge clk);
         ov = bus.out_valid;
         tick();
         cyc++;
         if (ov) begin
            got++;
            bus.ready_to_process = 1'b0;
            tick(); tick(); tick();
            bus.ready_to_process = 1'b1;
         end
      end
      chk("drain_pulses", got, n);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      reset                = 1'b1;
      bus.s_valid          = 1'b0;
      bus.s_data           = '0;
      bus.s_last           = 1'b0;
      bus.ready_to_process = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("s_ready_in_reset", 32'(bus.s_ready), 0);
      chk("out_valid_in_reset", 32'(bus.out_valid), 0);
      reset = 1'b0;
      tick();
      chk("s_ready_after_reset", 32'(bus.s_ready), 1);
      chk("level_reset", 32'(bus.fifo_level), 0);
      chk("drop_reset", 32'(bus.drop_count), 0);
      chk("malformed_reset", 32'(bus.malformed_count), 0);

      // TCP IHL=5, issue one cycle after the last word.
      bus.ready_to_process = 1'b1;
      set_tcp(32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
      exp_q.push_back(mk(32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'd6));
      send_pkt(pn, 1'b1);
      @(negedge clk);
      chk("issue_latency", 32'(bus.out_valid), 1);
      tick();
      bus.ready_to_process = 1'b0;
      tick();
      bus.ready_to_process = 1'b1;
      chk("malformed_tcp", 32'(bus.malformed_count), 0);

      // ICMP IHL=6: option word is not the port word.
      pn = 7;
      pw[0] = 32'h46000024; pw[1] = 32'h0; pw[2] = 32'h40010000;
      pw[3] = 32'hC0A80101; pw[4] = 32'hC0A80102; pw[5] = 32'hDEADBEEF; pw[6] = 32'hAAAABBBB;
      exp_q.push_back(mk(32'hC0A80101, 32'hC0A80102, 16'h0, 16'h0, 8'd1));
      send_pkt(pn, 1'b1);
      ack();

      // UDP IHL=6 with option, ports on w6, one payload word after.
      pn = 8;
      pw[0] = 32'h46000030; pw[1] = 32'h0; pw[2] = 32'h40110000;
      pw[3] = 32'hAC100005; pw[4] = 32'hAC100009; pw[5] = 32'h11112222;
      pw[6] = 32'h00351F90; pw[7] = 32'hCAFEF00D;
      exp_q.push_back(mk(32'hAC100005, 32'hAC100009, 16'h0035, 16'h1F90, 8'd17));
      send_pkt(pn, 1'b1);
      ack();

      // Non-first TCP fragment: ports forced to zero.
      set_tcp(32'h01020304, 32'h05060708, 16'h1111, 16'h2222);
      pw[1] = 32'h00000010;
      exp_q.push_back(mk(32'h01020304, 32'h05060708, 16'h0, 16'h0, 8'd6));
      send_pkt(pn, 1'b1);
      ack();
      chk("level_after_singles", 32'(bus.fifo_level), 0);

      // Malformed: version 6, then s_last on w3.
      pn = 3; pw[0] = 32'h60000000; pw[1] = 32'h0; pw[2] = 32'h0;
      send_pkt(pn, 1'b1);
      set_tcp(32'h0A0000AA, 32'h0A0000BB, 16'd1, 16'd2);
      pn = 4;
      send_pkt(pn, 1'b1);
      tick(); tick();
      chk("malformed_two", 32'(bus.malformed_count), 2);
      chk("level_malformed", 32'(bus.fifo_level), 0);
      pn = 1; pw[0] = 32'h45000028;
      send_pkt(pn, 1'b1);
      pn = 3; pw[0] = 32'h44000000;
      send_pkt(pn, 1'b1);
      tick();
      chk("malformed_four", 32'(bus.malformed_count), 4);

      // Nine packets into eight entries with ready low.
      bus.ready_to_process = 1'b0;
      for (int i = 0; i < 9; i++) begin
         set_tcp(32'h0A000100 + 32'(i), 32'h0A000002, 16'd1000 + 16'(i), 16'd80);
         if (i < 8) exp_q.push_back(mk(32'h0A000100 + 32'(i), 32'h0A000002, 16'd1000 + 16'(i), 16'd80, 8'd6));
         send_pkt(pn, 1'b1);
      end
      tick(); tick();
      chk("level_full", 32'(bus.fifo_level), 8);
      chk("drop_one", 32'(bus.drop_count), 1);
      drain(8);
      chk("level_drained", 32'(bus.fifo_level), 0);

      // Full FIFO: commit on the same edge as a pop is kept.
      bus.ready_to_process = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         set_tcp(32'h0B000000 + 32'(i), 32'h0B0000F0, 16'd2000 + 16'(i), 16'd443);
         exp_q.push_back(mk(32'h0B000000 + 32'(i), 32'h0B0000F0, 16'd2000 + 16'(i), 16'd443, 8'd6));
         send_pkt(pn, 1'b1);
      end
      chk("level_full_again", 32'(bus.fifo_level), 8);
      set_tcp(32'h0B0000FF, 32'h0B0000F0, 16'd3000, 16'd443);
      exp_q.push_back(mk(32'h0B0000FF, 32'h0B0000F0, 16'd3000, 16'd443, 8'd6));
      ready_on_last = 1'b1;
      send_pkt(pn, 1'b1);
      ready_on_last = 1'b0;
      bus.ready_to_process = 1'b0;
      tick();
      chk("drop_same_cycle_pop", 32'(bus.drop_count), 1);
      chk("level_same_cycle_pop", 32'(bus.fifo_level), 8);
      drain(8);

      // Reset mid-packet after w2, then a clean packet.
      set_tcp(32'h0C000001, 32'h0C000002, 16'd7, 16'd8);
      send_pkt(3, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      chk("drop_after_reset", 32'(bus.drop_count), 0);
      chk("malformed_after_reset", 32'(bus.malformed_count), 0);
      chk("level_after_reset", 32'(bus.fifo_level), 0);
      bus.ready_to_process = 1'b1;
      set_tcp(32'h0D000001, 32'h0D000002, 16'h15B3, 16'h1A0A);
      exp_q.push_back(mk(32'h0D000001, 32'h0D000002, 16'h15B3, 16'h1A0A, 8'd6));
      send_pkt(pn, 1'b1);
      ack();
      chk("malformed_clean", 32'(bus.malformed_count), 0);

`ifdef IPV4_CSUM_CHECK_EN
      set_tcp(32'h0E000001, 32'h0E000002, 16'd9, 16'd10);
      corrupt = 1'b1;
      send_pkt(pn, 1'b1);
      corrupt = 1'b0;
      tick(); tick(); tick();
      chk("malformed_csum", 32'(bus.malformed_count), 1);
      chk("level_csum", 32'(bus.fifo_level), 0);
`endif

      repeat (5) tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
